// File: rtl/display_pkg.sv
// Shared constants, FSM state type and blanking helper for the calculator
// display path (binary result -> BCD digits -> scanned 4-digit display).
package display_pkg;

    localparam int DIGITS  = 4;
    localparam int BIN_W   = 14;
    localparam int BCD_W   = 4 * DIGITS;
    localparam int BCD_MAX = 9999;

    localparam logic [DIGITS-1:0] ANODE_OFF = 4'b1111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } conv_state_e;

    // A digit is lit when it or any more significant digit is non-zero;
    // digit 0 is always lit so a zero value still shows "0".
    function automatic logic [DIGITS-1:0] lit_mask(input logic [BCD_W-1:0] d);
        logic seen;
        lit_mask = '0;
        seen     = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            seen        = seen | (d[4*i +: 4] != 4'd0);
            lit_mask[i] = seen || (i == 0);
        end
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one input bit per cycle, with a
// start/busy/done interface. done is high for the single COMMIT cycle.
module bin2bcd_seq
    import display_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    output logic             busy,
    output logic             done,
    output logic             over_max,
    output logic [BCD_W-1:0] bcd_out,
    output logic [1:0]       state_o
);

    localparam int               CNT_W    = $clog2(BIN_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    conv_state_e      state_q, state_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0] acc_q, acc_d;
    logic [BCD_W-1:0] adj;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CONV;
            CONV:    if (cnt_q == CNT_LAST) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Overflow is judged on the captured value; the 16-bit accumulator
    // silently drops the ten-thousands carry.
    always_comb begin
        bin_d = bin_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        adj   = acc_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d = bin_in;
                    acc_d = '0;
                    cnt_d = '0;
                    ovf_d = (bin_in > BIN_W'(BCD_MAX));
                end
            end
            CONV: begin
                {acc_d, bin_d} = {adj[BCD_W-2:0], bin_q, 1'b0};
                cnt_d          = cnt_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        busy     = (state_q != IDLE);
        done     = (state_q == COMMIT);
        over_max = ovf_q;
        bcd_out  = acc_q;
        state_o  = state_q;
    end

endmodule

// File: rtl/bcd_scan_driver.sv
// Converts a binary result to BCD and time-multiplexes the four digits onto
// the shared decoder input with active-low anodes and leading-zero blanking.
module bcd_scan_driver
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BIN_W-1:0]  value,
    input  logic              load,
    output logic              busy,
    output logic              overflow,
    output logic [3:0]        bcd_digit,
    output logic [DIGITS-1:0] an
);

    localparam int              PW         = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam int              IW         = $clog2(DIGITS);
    localparam logic [IW-1:0]   IDX_LAST   = IW'(DIGITS - 1);

    logic [BCD_W-1:0]  disp_q, disp_d;
    logic              ovf_q, ovf_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [3:0]        bcd_digit_q, bcd_digit_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [DIGITS-1:0] lit;

    logic              conv_busy;
    logic              conv_done;
    logic              conv_over;
    logic [BCD_W-1:0]  conv_bcd;
    logic [1:0]        conv_state;

    bin2bcd_seq u_conv (
        .clk      (clk),
        .rst      (rst),
        .start    (load),
        .bin_in   (value),
        .busy     (conv_busy),
        .done     (conv_done),
        .over_max (conv_over),
        .bcd_out  (conv_bcd),
        .state_o  (conv_state)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_q      <= '0;
            ovf_q       <= 1'b0;
            presc_q     <= '0;
            idx_q       <= '0;
            bcd_digit_q <= 4'd0;
            an_q        <= ANODE_OFF;
        end else begin
            disp_q      <= disp_d;
            ovf_q       <= ovf_d;
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            bcd_digit_q <= bcd_digit_d;
            an_q        <= an_d;
        end
    end

    // Display registers only change on the commit cycle, never mid-conversion.
    always_comb begin
        disp_d = disp_q;
        ovf_d  = ovf_q;
        if (conv_done) begin
            disp_d = conv_bcd;
            ovf_d  = conv_over;
        end
    end

    always_comb begin
        presc_d = presc_q + 1'b1;
        idx_d   = idx_q;
        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // Digit code and anode are registered together from the same index.
    always_comb begin
        lit         = lit_mask(disp_q);
        bcd_digit_d = disp_q[{idx_q, 2'b00} +: 4];
        an_d        = ANODE_OFF;
        if (!ovf_q && lit[idx_q]) an_d[idx_q] = 1'b0;
    end

    assign busy      = conv_busy;
    assign overflow  = ovf_q;
    assign bcd_digit = bcd_digit_q;
    assign an        = an_q;

    assert property (@(posedge clk) disable iff (rst) conv_done |-> (conv_state == COMMIT));

endmodule

// File: tb/tb_bcd_scan_driver.sv
// Scoreboard bench for bcd_scan_driver: a decimal-arithmetic display model
// plus a commit queue checked by an independent monitor.
module tb_bcd_scan_driver;

    localparam int RDIV = 4;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        load  = 1'b0;
    logic [13:0] value = '0;
    logic        busy;
    logic        overflow;
    logic [3:0]  bcd_digit;
    logic [3:0]  an;

    always #5 clk = ~clk;

    bcd_scan_driver #(.REFRESH_DIV(RDIV)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .value     (value),
        .load      (load),
        .busy      (busy),
        .overflow  (overflow),
        .bcd_digit (bcd_digit),
        .an        (an)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int pow10(input int i);
        int p = 1;
        repeat (i) p = p * 10;
        return p;
    endfunction

    // Expected frame: {overflow, lit[3:0], digit3..digit0}
    function automatic logic [20:0] frame_of(input int v);
        int         md;
        logic       ov;
        logic [3:0] lt;
        logic [15:0] dg;
        md = v % 10000;
        ov = (v > 9999);
        for (int i = 0; i < 4; i++) begin
            lt[i]       = !ov && (i == 0 || md >= pow10(i));
            dg[4*i +: 4] = 4'((md / pow10(i)) % 10);
        end
        return {ov, lt, dg};
    endfunction

    // ---------------- reference model ----------------
    int         m_disp  = 0;
    bit         m_ovf   = 1'b0;
    bit         m_busy  = 1'b0;
    int         m_left  = 0;
    int         m_pend  = 0;
    int         m_n     = 0;
    int         m_idx   = 0;
    logic [3:0] exp_an  = 4'hF;
    logic [3:0] exp_bcd = 4'h0;
    bit         exp_busy = 1'b0;
    bit         exp_ovf  = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_disp = 0; m_ovf = 1'b0; m_busy = 1'b0; m_left = 0; m_n = 0; m_idx = 0;
            exp_an = 4'hF; exp_bcd = 4'h0; exp_busy = 1'b0; exp_ovf = 1'b0;
        end else begin
            m_idx   = (m_n / RDIV) % 4;
            exp_bcd = 4'((m_disp / pow10(m_idx)) % 10);
            exp_an  = 4'hF;
            if (!m_ovf && (m_idx == 0 || m_disp >= pow10(m_idx))) exp_an[m_idx] = 1'b0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_disp = m_pend % 10000;
                    m_ovf  = (m_pend > 9999);
                    m_busy = 1'b0;
                end
            end else if (load) begin
                m_busy = 1'b1;
                m_left = 15;
                m_pend = int'(value);
            end
            m_n++;
            exp_busy = m_busy;
            exp_ovf  = m_ovf;
        end
    end

    // ---------------- scoreboard monitor ----------------
    logic [20:0] exp_q[$];
    logic [20:0] cur_exp   = '0;
    int          frame_cnt = 0;
    logic [15:0] obs_d     = '0;
    logic [3:0]  obs_lit   = '0;
    bit          prev_busy = 1'b0;
    int          busy_len  = 0;

    always @(negedge clk) begin
        if (rst) begin
            frame_cnt = 0;
            prev_busy = 1'b0;
            busy_len  = 0;
        end else begin
            check("an", an, exp_an);
            check("bcd_digit", bcd_digit, exp_bcd);
            check("busy", busy, exp_busy);
            check("overflow", overflow, exp_ovf);
            if (frame_cnt > 0) begin
                obs_d[4*m_idx +: 4] = bcd_digit;
                obs_lit[m_idx]      = ~an[m_idx];
                frame_cnt--;
                if (frame_cnt == 0) check("frame", {overflow, obs_lit, obs_d}, cur_exp);
            end
            if (busy) busy_len++;
            if (prev_busy && !busy) begin
                check("busy_len", busy_len, 15);
                busy_len = 0;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL commit: got a commit, expected none at %0t", $time);
                end else begin
                    cur_exp   = exp_q.pop_front();
                    frame_cnt = 16;
                    obs_d     = '0;
                    obs_lit   = '0;
                end
            end
            prev_busy = busy;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input int v);
        load  = 1'b1;
        value = 14'(v);
        if (!m_busy) exp_q.push_back(frame_of(v));
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((busy || m_busy) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            n_checks++;
            $display("FAIL wait_idle: busy still %0b, expected 0 within 100 cycles", busy);
        end
    endtask

    task automatic run_one(input int v);
        do_load(v);
        wait_idle();
        tick(20);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v;
        tick(3);
        check("rst_an", an, 4'hF);
        check("rst_bcd", bcd_digit, 4'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        rst = 1'b0;
        tick(20);

        run_one(1234);
        run_one(7);
        run_one(1000);
        run_one(10000);
        run_one(9999);

        do_load(4321);
        tick(5);
        do_load(1111);
        wait_idle();
        tick(20);

        load  = 1'b1;
        value = 14'd42;
        if (!m_busy) exp_q.push_back(frame_of(42));
        @(negedge clk);
        value = 14'd99;
        @(negedge clk);
        load = 1'b0;
        wait_idle();
        tick(20);

        do_load(5678);
        tick(6);
        #2 rst = 1'b1;
        #1;
        check("async_rst_an", an, 4'hF);
        check("async_rst_bcd", bcd_digit, 4'h0);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_ovf", overflow, 1'b0);
        exp_q.delete();
        tick(2);
        rst = 1'b0;
        tick(25);

        repeat (25) begin
            v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10000, 16383))
                                            : int'($urandom_range(0, 9999));
            do_load(v);
            if ($urandom_range(0, 1) == 1) begin
                tick(int'($urandom_range(1, 10)));
                do_load(int'($urandom_range(0, 16383)));
            end
            wait_idle();
            tick(int'($urandom_range(17, 24)));
        end

        tick(5);
        check("exp_q_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
